cp0_regs: RTL and testbench

CP0_REGS -- requirements
Module: cp0_regs

---
 rtl/cp0_pkg.sv | 36 +++
 rtl/cp0_timer.sv | 59 +++++
 rtl/cp0_regs.sv | 122 ++++++++++++
 tb/tb_cp0_regs.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, exception codes, Status reset
// value, writable-field masks and field bit positions.
package cp0_pkg;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    localparam int STATUS_EXL     = 1;
    localparam int CAUSE_BD       = 31;
    localparam int CAUSE_TI_IP    = 15;
    localparam int CAUSE_HW_IP_LO = 10;
    localparam int CAUSE_EXC_HI   = 6;
    localparam int CAUSE_EXC_LO   = 2;

    function automatic logic is_exception(input logic [31:0] code);
        return code inside {EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV};
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second clock, timer_int_o
// latches on a Count==Compare match and is cleared by a Compare write.
module cp0_timer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        tick_q, tick_d;
    logic        timer_int_q, timer_int_d;

    always_comb begin
        count_d     = count_q;
        tick_d      = ~tick_q;
        compare_d   = compare_q;
        timer_int_d = timer_int_q;

        if (count_we_i) begin
            count_d = wdata_i;
            tick_d  = 1'b0;
        end else if (tick_q) begin
            count_d = count_q + 32'd1;
        end

        // A Compare write wins over a match seen in the same cycle.
        if (compare_we_i) begin
            compare_d   = wdata_i;
            timer_int_d = 1'b0;
        end else if (compare_q != 32'd0 && count_q == compare_q) begin
            timer_int_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q     <= 32'd0;
            compare_q   <= 32'd0;
            tick_q      <= 1'b0;
            timer_int_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            compare_q   <= compare_d;
            tick_q      <= tick_d;
            timer_int_q <= timer_int_d;
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = timer_int_q;

endmodule

// File: rtl/cp0_regs.sv
// CP0 register file: MTC0/MFC0 access, exception entry/ERET bookkeeping
// and interrupt-pending sampling; the timer lives in cp0_timer.
module cp0_regs
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic        timer_int_o
);

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        exc_take, eret, mtc0_ok;

    cp0_timer u_timer (
        .clk          (clk),
        .resetn       (resetn),
        .count_we_i   (we_i && waddr_i == REG_COUNT),
        .compare_we_i (we_i && waddr_i == REG_COMPARE),
        .wdata_i      (data_i),
        .count_o      (count_o),
        .compare_o    (compare_o),
        .timer_int_o  (timer_int_o)
    );

    assign exc_take = is_exception(excepttype_i);
    assign eret     = (excepttype_i == EXC_ERET);
    assign mtc0_ok  = we_i && !exc_take && !eret;

    always_comb begin
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;

        cause_d[CAUSE_TI_IP]                    = int_i[5] | timer_int_o;
        cause_d[CAUSE_TI_IP-1:CAUSE_HW_IP_LO]   = int_i[4:0];

        if (exc_take) begin
            // A nested exception keeps the original return address and BD.
            if (!status_q[STATUS_EXL]) begin
                epc_d             = is_in_delayslot_i ? current_inst_addr_i - 32'd4
                                                      : current_inst_addr_i;
                cause_d[CAUSE_BD] = is_in_delayslot_i;
            end
            status_d[STATUS_EXL] = 1'b1;
            cause_d[CAUSE_EXC_HI:CAUSE_EXC_LO] = (excepttype_i == EXC_INT) ? 5'd0
                                                                          : excepttype_i[4:0];
            if (excepttype_i == EXC_ADEL || excepttype_i == EXC_ADES)
                badvaddr_d = bad_addr_i;
        end else if (eret) begin
            status_d[STATUS_EXL] = 1'b0;
        end else if (mtc0_ok) begin
            case (waddr_i)
                REG_STATUS: status_d = (status_q & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
                REG_CAUSE:  cause_d  = (cause_d & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
                REG_EPC:    epc_d    = data_i;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_q   <= STATUS_RESET;
            cause_q    <= 32'd0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    // Read port, with same-cycle MTC0 data bypassed through the write masks.
    always_comb begin
        data_o = 32'd0;
        case (raddr_i)
            REG_BADVADDR: data_o = badvaddr_q;
            REG_COUNT:    data_o = count_o;
            REG_COMPARE:  data_o = compare_o;
            REG_STATUS:   data_o = status_q;
            REG_CAUSE:    data_o = cause_q;
            REG_EPC:      data_o = epc_q;
            default:      data_o = 32'd0;
        endcase
        if (we_i && waddr_i == raddr_i) begin
            case (waddr_i)
                REG_COUNT, REG_COMPARE, REG_EPC: data_o = data_i;
                REG_STATUS: data_o = data_i & STATUS_WMASK;
                REG_CAUSE:  data_o = data_i & CAUSE_WMASK;
                default:    ;
            endcase
        end
    end

    assign status_o   = status_q;
    assign cause_o    = cause_q;
    assign epc_o      = epc_q;
    assign badvaddr_o = badvaddr_q;

endmodule

// File: tb/tb_cp0_regs.sv
// Bench for cp0_regs: directed scenarios followed by random MTC0/exception
// traffic, every output compared against a behavioural CP0 model.
module tb_cp0_regs;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] data_i;
    logic [4:0]  raddr_i;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] bad_addr_i;
    logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o;
    logic        timer_int_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [31:0] m_count, m_compare, m_status, m_cause, m_epc, m_bad;
    logic        m_timer;
    int          m_edges;

    int addr_pool [8]  = '{8, 9, 11, 12, 13, 14, 0, 21};
    int exc_pool  [20] = '{0, 0, 0, 0, 0, 0, 0, 0, 3, 32,
                           1, 4, 5, 8, 9, 10, 12, 14, 14, 14};

    cp0_regs dut (
        .clk                 (clk),
        .resetn              (resetn),
        .we_i                (we_i),
        .waddr_i             (waddr_i),
        .data_i              (data_i),
        .raddr_i             (raddr_i),
        .int_i               (int_i),
        .excepttype_i        (excepttype_i),
        .current_inst_addr_i (current_inst_addr_i),
        .is_in_delayslot_i   (is_in_delayslot_i),
        .bad_addr_i          (bad_addr_i),
        .data_o              (data_o),
        .count_o             (count_o),
        .compare_o           (compare_o),
        .status_o            (status_o),
        .cause_o             (cause_o),
        .epc_o               (epc_o),
        .badvaddr_o          (badvaddr_o),
        .timer_int_o         (timer_int_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_count   = 32'd0;
        m_compare = 32'd0;
        m_status  = 32'h0040_0000;
        m_cause   = 32'd0;
        m_epc     = 32'd0;
        m_bad     = 32'd0;
        m_timer   = 1'b0;
        m_edges   = 0;
    endtask

    function automatic logic [31:0] m_read();
        logic [31:0] v;
        case (raddr_i)
            5'd8:    v = m_bad;
            5'd9:    v = m_count;
            5'd11:   v = m_compare;
            5'd12:   v = m_status;
            5'd13:   v = m_cause;
            5'd14:   v = m_epc;
            default: v = 32'd0;
        endcase
        if (we_i && waddr_i == raddr_i) begin
            if (raddr_i == 5'd9 || raddr_i == 5'd11 || raddr_i == 5'd14) v = data_i;
            if (raddr_i == 5'd12) v = data_i & 32'h0000_ff03;
            if (raddr_i == 5'd13) v = data_i & 32'h0000_0300;
        end
        return v;
    endfunction

    // Applies one rising edge to the model from the inputs currently driven.
    task automatic model_edge();
        logic [31:0] c, cmp, st, ca, ep, bd;
        logic        ti, is_exc;
        int          ed;
        c = m_count; cmp = m_compare; st = m_status; ca = m_cause;
        ep = m_epc; bd = m_bad; ti = m_timer; ed = m_edges + 1;
        is_exc = excepttype_i inside {32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc};

        if (we_i && waddr_i == 5'd9) begin
            c  = data_i;
            ed = 0;
        end else if (ed % 2 == 0) begin
            c = m_count + 32'd1;
        end
        if (we_i && waddr_i == 5'd11) begin
            cmp = data_i;
            ti  = 1'b0;
        end else if (m_compare != 0 && m_count == m_compare) begin
            ti = 1'b1;
        end

        ca[15]    = int_i[5] | m_timer;
        ca[14:10] = int_i[4:0];
        if (is_exc) begin
            if (m_status[1] == 1'b0) begin
                ep     = is_in_delayslot_i ? current_inst_addr_i - 4 : current_inst_addr_i;
                ca[31] = is_in_delayslot_i;
            end
            st[1]   = 1'b1;
            ca[6:2] = (excepttype_i == 32'h1) ? 5'd0 : excepttype_i[4:0];
            if (excepttype_i == 32'h4 || excepttype_i == 32'h5) bd = bad_addr_i;
        end else if (excepttype_i == 32'he) begin
            st[1] = 1'b0;
        end else if (we_i) begin
            if (waddr_i == 5'd12) st = 32'h0040_0000 | (data_i & 32'h0000_ff03);
            if (waddr_i == 5'd13) ca[9:8] = data_i[9:8];
            if (waddr_i == 5'd14) ep = data_i;
        end

        m_count = c; m_compare = cmp; m_status = st; m_cause = ca;
        m_epc = ep; m_bad = bd; m_timer = ti; m_edges = ed;
    endtask

    task automatic check_all(input string pfx);
        check_eq({pfx, ".count"},    count_o,    m_count);
        check_eq({pfx, ".compare"},  compare_o,  m_compare);
        check_eq({pfx, ".status"},   status_o,   m_status);
        check_eq({pfx, ".cause"},    cause_o,    m_cause);
        check_eq({pfx, ".epc"},      epc_o,      m_epc);
        check_eq({pfx, ".badvaddr"}, badvaddr_o, m_bad);
        check_eq({pfx, ".timer"},    {31'd0, timer_int_o}, {31'd0, m_timer});
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        #1;
        check_eq("data_o", data_o, m_read());
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all("cyc");
    endtask

    task automatic set_idle();
        we_i = 1'b0; waddr_i = 5'd0; data_i = 32'd0; raddr_i = 5'd9;
        int_i = 6'd0; excepttype_i = 32'd0; current_inst_addr_i = 32'd0;
        is_in_delayslot_i = 1'b0; bad_addr_i = 32'd0;
    endtask

    task automatic mid_reset();
        @(negedge clk);
        set_idle();
        #2 resetn = 1'b0;
        model_reset();
        #1;
        check_all("arst");
        check_eq("arst.status_const", status_o, 32'h0040_0000);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        logic seen;
        set_idle();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all("rst");
        resetn = 1'b1;

        repeat (10) tick();
        check_eq("cnt10", count_o, 32'd5);
        check_eq("status10", status_o, 32'h0040_0000);
        check_eq("timer10", {31'd0, timer_int_o}, 32'd0);

        // Timer: Count=0, Compare=3, watch the interrupt rise and clear
        set_idle(); we_i = 1'b1; waddr_i = 5'd9; data_i = 32'd0; tick();
        set_idle(); we_i = 1'b1; waddr_i = 5'd11; data_i = 32'd3; tick();
        set_idle();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (count_o == 32'd3) seen = 1'b1;
        end
        check_eq("cnt_reach3", {31'd0, seen}, 32'd1);
        check_eq("ti_before", {31'd0, timer_int_o}, 32'd0);
        tick();
        check_eq("ti_rise", {31'd0, timer_int_o}, 32'd1);
        repeat (4) tick();
        check_eq("ti_hold", {31'd0, timer_int_o}, 32'd1);
        we_i = 1'b1; waddr_i = 5'd11; data_i = 32'd0; tick();
        set_idle();
        check_eq("ti_clear", {31'd0, timer_int_o}, 32'd0);

        // Count wrap
        we_i = 1'b1; waddr_i = 5'd9; data_i = 32'hffff_ffff; tick();
        set_idle(); tick(); tick();
        check_eq("cnt_wrap", count_o, 32'd0);

        // Address error in a delay slot
        excepttype_i = 32'h4; current_inst_addr_i = 32'hbfc0_0100;
        is_in_delayslot_i = 1'b1; bad_addr_i = 32'h13; tick();
        set_idle();
        check_eq("adel.epc", epc_o, 32'hbfc0_00fc);
        check_eq("adel.bd", {31'd0, cause_o[31]}, 32'd1);
        check_eq("adel.exc", {27'd0, cause_o[6:2]}, 32'd4);
        check_eq("adel.bad", badvaddr_o, 32'h13);
        check_eq("adel.exl", {31'd0, status_o[1]}, 32'd1);

        // Nested overflow keeps EPC, then ERET
        excepttype_i = 32'hc; current_inst_addr_i = 32'h8000_0000; tick();
        set_idle();
        check_eq("ov.epc", epc_o, 32'hbfc0_00fc);
        check_eq("ov.exc", {27'd0, cause_o[6:2]}, 32'hc);
        excepttype_i = 32'he; tick();
        set_idle();
        check_eq("eret.exl", {31'd0, status_o[1]}, 32'd0);

        // MTC0 Status collides with syscall
        we_i = 1'b1; waddr_i = 5'd12; data_i = 32'hffff_ffff;
        excepttype_i = 32'h8; current_inst_addr_i = 32'h8000_1000; tick();
        set_idle();
        check_eq("sys.status", status_o, 32'h0040_0002);
        check_eq("sys.exc", {27'd0, cause_o[6:2]}, 32'd8);

        // Cause write forwarded to the read port
        we_i = 1'b1; waddr_i = 5'd13; data_i = 32'hffff_ffff; raddr_i = 5'd13;
        #1;
        check_eq("fwd.cause", data_o, 32'h0000_0300);
        tick();
        set_idle();
        repeat (5) tick();
        mid_reset();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            we_i                = ($urandom_range(0, 2) == 0);
            waddr_i             = 5'(addr_pool[$urandom_range(0, 7)]);
            raddr_i             = 5'(addr_pool[$urandom_range(0, 7)]);
            data_i              = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
            int_i               = 6'($urandom_range(0, 63));
            excepttype_i        = 32'(exc_pool[$urandom_range(0, 19)]);
            current_inst_addr_i = $urandom & 32'hffff_fffc;
            is_in_delayslot_i   = 1'($urandom_range(0, 1));
            bad_addr_i          = $urandom;
            tick();
            if (i == 200) mid_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
